// File: rtl/iobuf_ctrl.sv
// Direction/mode controller for a 74LVC1T45 + 74LVC1G07 header buffer pair, with a
// synchronized, edge-detected input path from the FPGA data pin.
module iobuf_ctrl #(
    parameter int TURN_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode_req,
    input  logic       mode_valid,
    output logic       mode_ready,
    output logic [1:0] mode_cur,
    input  logic       dout,
    output logic       din,
    output logic       din_rise,
    output logic       din_fall,
    output logic       bufdir,
    output logic       bufod,
    output logic       bufdat_tristate_oe,
    output logic       bufdat_tristate_dout,
    input  logic       bufdat_tristate_din
);

    typedef enum logic [2:0] {
        S_IN,
        S_PP,
        S_OD,
        S_TURN_ON,
        S_TURN_OFF
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(TURN_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] target, target_nxt;
    logic [1:0] mode_cur_nxt;
    logic [1:0] req_mode;
    logic       accept;
    logic       dir_nxt, od_nxt, oe_nxt, dat_nxt;
    logic       pin_p0, pin_p1, pin_p2;

    assign mode_ready = (state == S_IN) || (state == S_PP) || (state == S_OD);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        target_nxt   = target;
        mode_cur_nxt = mode_cur;
        req_mode     = (mode_req == 2'd3) ? 2'd0 : mode_req;
        accept       = mode_valid && mode_ready;

        case (state)
            S_IN, S_OD: begin
                if (accept && (req_mode != mode_cur)) begin
                    target_nxt = req_mode;
                    if (req_mode == 2'd1) begin
                        state_nxt = S_TURN_ON;
                        cnt_nxt   = 4'd0;
                    end else begin
                        // IN <-> OD keeps the level shifter as input, so no turnaround
                        state_nxt    = (req_mode == 2'd2) ? S_OD : S_IN;
                        mode_cur_nxt = req_mode;
                    end
                end
            end
            S_PP: begin
                if (accept && (req_mode != 2'd1)) begin
                    state_nxt  = S_TURN_OFF;
                    cnt_nxt    = 4'd0;
                    target_nxt = req_mode;
                end
            end
            S_TURN_ON: begin
                if (cnt == CNT_LAST) begin
                    state_nxt    = S_PP;
                    mode_cur_nxt = 2'd1;
                    cnt_nxt      = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_TURN_OFF: begin
                if (cnt == CNT_LAST) begin
                    state_nxt    = (target == 2'd2) ? S_OD : S_IN;
                    mode_cur_nxt = target;
                    cnt_nxt      = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt    = S_IN;
                cnt_nxt      = 4'd0;
                mode_cur_nxt = 2'd0;
            end
        endcase

        // Pad outputs are a registered function of the next state, so oe drops on
        // the accept edge of a turn-off and bufdir leads oe on a turn-on.
        dir_nxt = 1'b0;
        od_nxt  = 1'b1;
        oe_nxt  = 1'b0;
        dat_nxt = 1'b0;
        case (state_nxt)
            S_PP: begin
                dir_nxt = 1'b1;
                oe_nxt  = 1'b1;
                dat_nxt = dout;
            end
            S_OD:       od_nxt  = dout;
            S_TURN_ON:  dir_nxt = 1'b1;
            S_TURN_OFF: dir_nxt = 1'b1;
            default:    dir_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= S_IN;
            cnt                  <= 4'd0;
            target               <= 2'd0;
            mode_cur             <= 2'd0;
            bufdir               <= 1'b0;
            bufod                <= 1'b1;
            bufdat_tristate_oe   <= 1'b0;
            bufdat_tristate_dout <= 1'b0;
        end else begin
            state                <= state_nxt;
            cnt                  <= cnt_nxt;
            target               <= target_nxt;
            mode_cur             <= mode_cur_nxt;
            bufdir               <= dir_nxt;
            bufod                <= od_nxt;
            bufdat_tristate_oe   <= oe_nxt;
            bufdat_tristate_dout <= dat_nxt;
        end
    end

    // p0/p1: metastability synchronizer; p2: history for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pin_p0 <= 1'b0;
            pin_p1 <= 1'b0;
            pin_p2 <= 1'b0;
        end else begin
            pin_p0 <= bufdat_tristate_din;
            pin_p1 <= pin_p0;
            pin_p2 <= pin_p1;
        end
    end

    assign din      = pin_p1;
    assign din_rise = pin_p1 & ~pin_p2;
    assign din_fall = ~pin_p1 & pin_p2;

endmodule

// File: tb/tb_iobuf_ctrl.sv
// Scenario bench for iobuf_ctrl: directed mode transitions, input path, and a
// random request stream against a countdown model of the controller.
module tb_iobuf_ctrl;

    localparam int TC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode_req = 2'd0;
    logic       mode_valid = 1'b0;
    logic       dout = 1'b0;
    logic       pin = 1'b0;
    logic       mode_ready, din, din_rise, din_fall;
    logic       bufdir, bufod, bufdat_tristate_oe, bufdat_tristate_dout;
    logic [1:0] mode_cur;
    logic [5:0] obs;

    int vectors = 0;
    int miscompares = 0;
    bit sbq[$];

    iobuf_ctrl #(.TURN_CYCLES(TC)) dut (
        .clock                (clock),
        .reset                (reset),
        .mode_req             (mode_req),
        .mode_valid           (mode_valid),
        .mode_ready           (mode_ready),
        .mode_cur             (mode_cur),
        .dout                 (dout),
        .din                  (din),
        .din_rise             (din_rise),
        .din_fall             (din_fall),
        .bufdir               (bufdir),
        .bufod                (bufod),
        .bufdat_tristate_oe   (bufdat_tristate_oe),
        .bufdat_tristate_dout (bufdat_tristate_dout),
        .bufdat_tristate_din  (pin)
    );

    // {bufdir, bufod, oe, mode_ready, mode_cur}
    assign obs = {bufdir, bufod, bufdat_tristate_oe, mode_ready, mode_cur};

    always #5 clock = ~clock;

    always @(negedge clock) begin
        vectors++;
        if (bufdir === 1'b0 && bufdat_tristate_oe === 1'b1) begin
            miscompares++;
            $display("FAIL dir_oe_invariant t=%0t: bufdir=%b oe=%b, required not (0,1)", $time, bufdir, bufdat_tristate_oe);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (obs !== 6'b010100) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want %b", obs, 6'b010100);
        end
        vectors++;
        if ({din, din_rise, din_fall, bufdat_tristate_dout} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_data: got %b want %b", {din, din_rise, din_fall, bufdat_tristate_dout}, 4'b0000);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (obs !== 6'b010100) begin
            miscompares++;
            $display("FAIL reset_release: got %b want %b", obs, 6'b010100);
        end
    endtask

    task automatic test_turn_on;
        logic [5:0] exp_seq [3];
        exp_seq[0] = 6'b110000;
        exp_seq[1] = 6'b110000;
        exp_seq[2] = 6'b111101;
        mode_req = 2'd1;
        mode_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            mode_valid = 1'b0;
            vectors++;
            if (obs !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL turn_on[%0d]: got %b want %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_pp_data;
        bit e;
        for (int i = 0; i < 8; i++) begin
            dout = 1'($urandom_range(0, 1));
            sbq.push_back(dout);
            tick();
            e = sbq.pop_front();
            vectors++;
            if (bufdat_tristate_dout !== e || obs !== 6'b111101) begin
                miscompares++;
                $display("FAIL pp_data[%0d]: got dat=%b ctrl=%b want dat=%b ctrl=%b", i, bufdat_tristate_dout, obs, e, 6'b111101);
            end
        end
    endtask

    task automatic test_turn_off;
        logic [5:0] exp_seq [6];
        exp_seq[0] = 6'b110001;
        exp_seq[1] = 6'b110001;
        for (int i = 2; i < 6; i++) exp_seq[i] = 6'b010100;
        mode_req = 2'd0;
        mode_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dout = ~dout;
            tick();
            mode_valid = 1'b0;
            vectors++;
            if (obs !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL turn_off[%0d]: got %b want %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_od;
        logic [5:0] exp_seq [7];
        logic       d_seq   [7];
        exp_seq[0] = 6'b000110; d_seq[0] = 1'b0;
        exp_seq[1] = 6'b010110; d_seq[1] = 1'b1;
        exp_seq[2] = 6'b000110; d_seq[2] = 1'b0;
        exp_seq[3] = 6'b110010; d_seq[3] = 1'b0;
        exp_seq[4] = 6'b110010; d_seq[4] = 1'b0;
        exp_seq[5] = 6'b111101; d_seq[5] = 1'b0;
        exp_seq[6] = 6'b111101; d_seq[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mode_valid = (i == 0) || (i == 3);
            mode_req   = (i == 0) ? 2'd2 : 2'd1;
            dout       = d_seq[i];
            tick();
            mode_valid = 1'b0;
            vectors++;
            if (obs !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL od_path[%0d]: got %b want %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_ignore_busy;
        logic [5:0] exp_seq [3];
        exp_seq[0] = 6'b110000;
        exp_seq[1] = 6'b111101;
        exp_seq[2] = 6'b111101;
        mode_req = 2'd0;
        mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        tick();
        tick();
        mode_req = 2'd1;
        mode_valid = 1'b1;
        tick();
        mode_req = 2'd2;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mode_valid = 1'b0;
            tick();
            vectors++;
            if (obs !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL ignore_busy[%0d]: got %b want %b", i, obs, exp_seq[i]);
            end
        end
        mode_valid = 1'b0;
    endtask

    task automatic test_same_mode_pp;
        mode_req = 2'd1;
        mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        vectors++;
        if (obs !== 6'b111101) begin
            miscompares++;
            $display("FAIL same_mode_pp: got %b want %b", obs, 6'b111101);
        end
    endtask

    task automatic test_reset_mid_turn;
        mode_req = 2'd0;
        mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        vectors++;
        if (obs !== 6'b110001) begin
            miscompares++;
            $display("FAIL pre_reset_turn_off: got %b want %b", obs, 6'b110001);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (obs !== 6'b010100 || bufdat_tristate_dout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_turn: got %b/%b want %b/0", obs, bufdat_tristate_dout, 6'b010100);
        end
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (obs !== 6'b010100) begin
            miscompares++;
            $display("FAIL reset_mid_turn_release: got %b want %b", obs, 6'b010100);
        end
    endtask

    task automatic test_same_mode_in;
        for (int i = 0; i < 2; i++) begin
            mode_req = (i == 0) ? 2'd0 : 2'd3;
            mode_valid = 1'b1;
            tick();
            mode_valid = 1'b0;
            tick();
            vectors++;
            if (obs !== 6'b010100) begin
                miscompares++;
                $display("FAIL same_mode_in req=%0d: got %b want %b", mode_req, obs, 6'b010100);
            end
        end
    endtask

    task automatic test_input_path;
        bit e, prev;
        int nrise, nfall;
        logic v;
        pin = 1'b0;
        repeat (4) tick();
        sbq.delete();
        prev = 1'b0;
        nrise = 0;
        nfall = 0;
        for (int i = 0; i < 22; i++) begin
            if (i > 0) tick();
            if (sbq.size() >= 2) begin
                e = sbq.pop_front();
                vectors++;
                if ({din, din_rise, din_fall} !== {e, e & ~prev, ~e & prev}) begin
                    miscompares++;
                    $display("FAIL input_path[%0d]: got din/rise/fall=%b want %b", i, {din, din_rise, din_fall}, {e, e & ~prev, ~e & prev});
                end
                prev = e;
            end
            if (din_rise === 1'b1) nrise++;
            if (din_fall === 1'b1) nfall++;
            if (i < 20) begin
                v = (i >= 5) && (i < 10);
                pin = v;
                sbq.push_back(v);
            end
        end
        vectors++;
        if (nrise != 1 || nfall != 1) begin
            miscompares++;
            $display("FAIL edge_pulse_count: got rise=%0d fall=%0d want 1 and 1", nrise, nfall);
        end
    endtask

    task automatic test_random;
        int         busy;
        logic [1:0] m_cur, tgt, r, rr;
        logic       v, d;
        logic [5:0] e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        busy = 0;
        m_cur = 2'd0;
        tgt = 2'd0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) == 0);
            r = 2'($urandom_range(0, 3));
            d = 1'($urandom_range(0, 1));
            mode_valid = v;
            mode_req = r;
            dout = d;
            if (busy > 0) begin
                busy--;
                if (busy == 0) m_cur = tgt;
            end else if (v) begin
                rr = (r == 2'd3) ? 2'd0 : r;
                if (rr != m_cur) begin
                    if (rr == 2'd1 || m_cur == 2'd1) begin
                        busy = TC;
                        tgt = rr;
                    end else begin
                        m_cur = rr;
                    end
                end
            end
            if (busy > 0)             e = {4'b1100, m_cur};
            else if (m_cur == 2'd1)   e = 6'b111101;
            else if (m_cur == 2'd2)   e = {1'b0, d, 4'b0110};
            else                      e = 6'b010100;
            tick();
            vectors++;
            if (obs !== e || (busy == 0 && m_cur == 2'd1 && bufdat_tristate_dout !== d)) begin
                miscompares++;
                $display("FAIL random[%0d]: got %b dat=%b want %b dat=%b", i, obs, bufdat_tristate_dout, e, d);
            end
        end
        mode_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_turn_on();
        test_pp_data();
        test_turn_off();
        test_od();
        test_ignore_busy();
        test_same_mode_pp();
        test_reset_mid_turn();
        test_same_mode_in();
        test_input_path();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
